// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the calculator initiator.
//   Operand/result widths, the calculator op encodings, the initiator FSM
//   state encoding and the packed command entry held in the command FIFO.
package calc_pkg;

   localparam int OPND_W = 8;
   localparam int RES_W  = 16;
   localparam int OP_W   = 2;
   localparam int CMD_W  = OP_W + 2 * OPND_W;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } calc_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } state_e;

   // FIFO entry layout {op, a, b}
   typedef struct packed {
      calc_op_e          op;
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
   } cmd_t;

endpackage

// File: rtl/calc_initiator_if.sv
// calc_initiator_if -- bundles the three handshakes of the initiator.
//   cmd_*  : command push port (valid/ready), operands and op
//   calc_* : calculator side, operands/op/start out, result/done/dbz in
//   rsp_*  : response port (valid/ready), result, op, dbz and timeout flags
// Modports: master = initiator side, slave = environment side.
interface calc_initiator_if;
   import calc_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [OPND_W-1:0]    cmd_a;
   logic [OPND_W-1:0]    cmd_b;
   logic [OP_W-1:0]      cmd_op;

   logic [OPND_W-1:0]    calc_a;
   logic [OPND_W-1:0]    calc_b;
   logic [OP_W-1:0]      calc_op;
   logic                 calc_start;
   logic [RES_W-1:0]     calc_result;
   logic                 calc_done;
   logic                 calc_dbz;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [RES_W-1:0]     rsp_result;
   logic [OP_W-1:0]      rsp_op;
   logic                 rsp_dbz;
   logic                 rsp_timeout;

   modport master (
      input  cmd_valid, cmd_a, cmd_b, cmd_op,
      output cmd_ready,
      output calc_a, calc_b, calc_op, calc_start,
      input  calc_result, calc_done, calc_dbz,
      output rsp_valid, rsp_result, rsp_op, rsp_dbz, rsp_timeout,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_a, cmd_b, cmd_op,
      input  cmd_ready,
      input  calc_a, calc_b, calc_op, calc_start,
      output calc_result, calc_done, calc_dbz,
      input  rsp_valid, rsp_result, rsp_op, rsp_dbz, rsp_timeout,
      output rsp_ready
   );

endinterface

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo -- synchronous command FIFO.
//   clk, rst_n          : clock, async active-low reset (empties the FIFO)
//   push, push_data     : write request and entry
//   pop, pop_data       : read request and head entry (head is combinational)
//   full, empty         : status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A pop in the same cycle as a push on a full FIFO frees the slot being
// written: the head is read out before the edge overwrites it.
module calc_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/calc_initiator.sv
// calc_initiator -- queues calculator commands and sequences them onto a
// calculator, returning one response per command in order.
//   clk, rst_n : clock, async active-low reset
//   bus        : calc_initiator_if.master (cmd_*, calc_*, rsp_* handshakes)
//   busy       : FSM not idle or commands still queued
// ADD/SUB/MUL results are combinational in the calculator and are sampled
// after one WAIT cycle; DIV is started with a one-cycle calc_start and
// completes on calc_done.
// Optional build macro CALC_TIMEOUT_EN: bounds the DIV wait to TIMEOUT_CYC
// cycles, after which a timeout response (result 16'hFFFF) is returned.
//
//   state | meaning
//   IDLE  | nothing in flight; pops the FIFO head when non-empty
//   ISSUE | operands presented; calc_start pulsed for DIV
//   WAIT  | one cycle for ADD/SUB/MUL, until calc_done (or timeout) for DIV
//   RESP  | rsp_valid held with captured fields until rsp_ready
module calc_initiator
   import calc_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   calc_initiator_if.master   bus,
   output logic               busy
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_e            state_q, state_d;
   logic [OPND_W-1:0] calc_a_q, calc_a_d;
   logic [OPND_W-1:0] calc_b_q, calc_b_d;
   calc_op_e          calc_op_q, calc_op_d;
   logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
   calc_op_e          rsp_op_q, rsp_op_d;
   logic              rsp_dbz_q, rsp_dbz_d;
   logic              calc_start;

   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              cmd_ready;
   logic [CMD_W-1:0]  fifo_rdata;
   cmd_t              fifo_head;

`ifdef CALC_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              rsp_timeout_q, rsp_timeout_d;
`endif

   // A pop in this cycle frees a slot, so a full FIFO can still accept.
   assign cmd_ready = !fifo_full || fifo_pop;
   assign fifo_head = cmd_t'(fifo_rdata);

   calc_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bus.cmd_valid && cmd_ready),
      .push_data ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      calc_a_d     = calc_a_q;
      calc_b_d     = calc_b_q;
      calc_op_d    = calc_op_q;
      rsp_result_d = rsp_result_q;
      rsp_op_d     = rsp_op_q;
      rsp_dbz_d    = rsp_dbz_q;
      fifo_pop     = 1'b0;
      calc_start   = 1'b0;
`ifdef CALC_TIMEOUT_EN
      timer_d       = timer_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               calc_a_d  = fifo_head.a;
               calc_b_d  = fifo_head.b;
               calc_op_d = fifo_head.op;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (calc_op_q == OP_DIV) begin
               calc_start = 1'b1;
`ifdef CALC_TIMEOUT_EN
               timer_d    = TMR_W'(TIMEOUT_CYC - 1);
`endif
            end
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // calc_done only matters for DIV; done on the expiry cycle wins.
            if (calc_op_q != OP_DIV || bus.calc_done) begin
               rsp_result_d = bus.calc_result;
               rsp_op_d     = calc_op_q;
               rsp_dbz_d    = (calc_op_q == OP_DIV) && bus.calc_dbz;
`ifdef CALC_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               state_d      = S_RESP;
            end
`ifdef CALC_TIMEOUT_EN
            else if (timer_q == '0) begin
               rsp_result_d  = 16'hFFFF;
               rsp_op_d      = calc_op_q;
               rsp_dbz_d     = 1'b0;
               rsp_timeout_d = 1'b1;
               state_d       = S_RESP;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
`endif
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         calc_a_q     <= '0;
         calc_b_q     <= '0;
         calc_op_q    <= OP_ADD;
         rsp_result_q <= '0;
         rsp_op_q     <= OP_ADD;
         rsp_dbz_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         calc_a_q     <= calc_a_d;
         calc_b_q     <= calc_b_d;
         calc_op_q    <= calc_op_d;
         rsp_result_q <= rsp_result_d;
         rsp_op_q     <= rsp_op_d;
         rsp_dbz_q    <= rsp_dbz_d;
      end
   end

`ifdef CALC_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q       <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   assign bus.rsp_timeout = 1'b0;
`endif

   assign bus.cmd_ready  = cmd_ready;
   assign bus.calc_a     = calc_a_q;
   assign bus.calc_b     = calc_b_q;
   assign bus.calc_op    = calc_op_q;
   assign bus.calc_start = calc_start;
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_op     = rsp_op_q;
   assign bus.rsp_dbz    = rsp_dbz_q;
   assign busy           = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_calc_initiator.sv
// tb_calc_initiator -- directed bench for calc_initiator with a behavioural
// calculator: ADD/SUB/MUL combinational, DIV returns {remainder, quotient}
// with done a programmable number of cycles after calc_start.
module tb_calc_initiator;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;

   int   n_checks = 0;
   int   n_pass   = 0;

   int   div_delay;
   bit   div_hang;
   logic stray_done;
   int   mdl_cnt;
   int   start_cnt = 0;
   logic [15:0] mdl_result;

   calc_initiator_if bus ();

   calc_initiator #(
      .FIFO_DEPTH  (4),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      mdl_result = 16'h0000;
      case (bus.calc_op)
         2'b00: mdl_result = {8'h00, bus.calc_a} + {8'h00, bus.calc_b};
         2'b01: mdl_result = {8'h00, bus.calc_a} - {8'h00, bus.calc_b};
         2'b10: mdl_result = {8'h00, bus.calc_a} * {8'h00, bus.calc_b};
         default: begin
            if (bus.calc_b != 8'h00)
               mdl_result = {bus.calc_a % bus.calc_b, bus.calc_a / bus.calc_b};
         end
      endcase
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdl_cnt <= 0;
      else if (bus.calc_start) mdl_cnt <= div_delay;
      else if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
   end

   always @(posedge clk) begin
      if (bus.calc_start) start_cnt <= start_cnt + 1;
   end

   assign bus.calc_result = mdl_result;
   assign bus.calc_done   = ((mdl_cnt == 1) && !div_hang) || stray_done;
   assign bus.calc_dbz    = (bus.calc_op == 2'b11) && (bus.calc_b == 8'h00);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      int budget = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      chk("push_ready", {31'd0, bus.cmd_ready}, 32'd1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic measure_lat(output int lat);
      lat = 0;
      while (lat < 300) begin
         @(negedge clk);
         if (bus.rsp_valid) break;
         lat++;
      end
   endtask

   task automatic wait_rsp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op, input logic [15:0] res,
                           input logic dbz, input logic tmo);
      int budget = 0;
      @(negedge clk);
      while (!bus.rsp_valid && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      chk({tag, "_valid"},   {31'd0, bus.rsp_valid},   32'd1);
      chk({tag, "_result"},  {16'd0, bus.rsp_result},  {16'd0, res});
      chk({tag, "_op"},      {30'd0, bus.rsp_op},      {30'd0, op});
      chk({tag, "_dbz"},     {31'd0, bus.rsp_dbz},     {31'd0, dbz});
      chk({tag, "_timeout"}, {31'd0, bus.rsp_timeout}, {31'd0, tmo});
      chk({tag, "_calc_a"},  {24'd0, bus.calc_a},      {24'd0, a});
      chk({tag, "_calc_b"},  {24'd0, bus.calc_b},      {24'd0, b});
      chk({tag, "_calc_op"}, {30'd0, bus.calc_op},     {30'd0, op});
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_ready"},   {31'd0, bus.cmd_ready},   32'd1);
      chk({tag, "_calc_start"},  {31'd0, bus.calc_start},  32'd0);
      chk({tag, "_calc_a"},      {24'd0, bus.calc_a},      32'd0);
      chk({tag, "_calc_b"},      {24'd0, bus.calc_b},      32'd0);
      chk({tag, "_calc_op"},     {30'd0, bus.calc_op},     32'd0);
      chk({tag, "_rsp_valid"},   {31'd0, bus.rsp_valid},   32'd0);
      chk({tag, "_rsp_result"},  {16'd0, bus.rsp_result},  32'd0);
      chk({tag, "_rsp_op"},      {30'd0, bus.rsp_op},      32'd0);
      chk({tag, "_rsp_dbz"},     {31'd0, bus.rsp_dbz},     32'd0);
      chk({tag, "_rsp_timeout"}, {31'd0, bus.rsp_timeout}, 32'd0);
      chk({tag, "_busy"},        {31'd0, busy},            32'd0);
   endtask

   initial begin
      int lat;
      int starts0;
      int seen;

      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = 8'h00;
      bus.cmd_b     = 8'h00;
      bus.cmd_op    = 2'b00;
      bus.rsp_ready = 1'b0;
      stray_done    = 1'b0;
      div_delay     = 6;
      div_hang      = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // stray calc_done while idle is ignored
      @(negedge clk) stray_done = 1'b1;
      @(negedge clk) stray_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("stray_busy",      {31'd0, busy},          32'd0);

      // single ADD: 3-cycle pop-to-valid latency, no calc_start
      starts0 = start_cnt;
      push(8'd10, 8'd5, 2'b00);
      measure_lat(lat);
      chk("add_latency", lat, 3);
      wait_rsp("add", 8'd10, 8'd5, 2'b00, 16'd15, 1'b0, 1'b0);
      chk("add_no_start", start_cnt - starts0, 0);

      // back-to-back ADD, SUB, MUL
      push(8'd10, 8'd5, 2'b00);
      push(8'd10, 8'd5, 2'b01);
      push(8'd10, 8'd5, 2'b10);
      wait_rsp("b2b_add", 8'd10, 8'd5, 2'b00, 16'd15, 1'b0, 1'b0);
      wait_rsp("b2b_sub", 8'd10, 8'd5, 2'b01, 16'd5,  1'b0, 1'b0);
      wait_rsp("b2b_mul", 8'd10, 8'd5, 2'b10, 16'd50, 1'b0, 1'b0);

      // DIV 13/4, done 6 cycles after calc_start
      starts0 = start_cnt;
      push(8'd13, 8'd4, 2'b11);
      measure_lat(lat);
      chk("div_latency", lat, 8);
      wait_rsp("div", 8'd13, 8'd4, 2'b11, 16'h0103, 1'b0, 1'b0);
      chk("div_one_start", start_cnt - starts0, 1);

      // DIV by zero
      push(8'd20, 8'd0, 2'b11);
      wait_rsp("dbz", 8'd20, 8'd0, 2'b11, 16'h0000, 1'b1, 1'b0);

      // backpressure: 1 in flight + 4 queued fills everything
      push(8'd1, 8'd1, 2'b00);
      push(8'd2, 8'd2, 2'b00);
      push(8'd9, 8'd3, 2'b01);
      push(8'd3, 8'd4, 2'b10);
      push(8'd7, 8'd8, 2'b00);
      @(negedge clk);
      chk("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("full_busy",      {31'd0, busy},          32'd1);
      chk("held_valid0",    {31'd0, bus.rsp_valid}, 32'd1);
      chk("held_result0",   {16'd0, bus.rsp_result}, 32'd2);
      repeat (5) @(negedge clk);
      chk("held_valid5",    {31'd0, bus.rsp_valid}, 32'd1);
      chk("held_result5",   {16'd0, bus.rsp_result}, 32'd2);
      chk("held_ready5",    {31'd0, bus.cmd_ready}, 32'd0);
      wait_rsp("drain0", 8'd1, 8'd1, 2'b00, 16'd2,  1'b0, 1'b0);
      wait_rsp("drain1", 8'd2, 8'd2, 2'b00, 16'd4,  1'b0, 1'b0);
      wait_rsp("drain2", 8'd9, 8'd3, 2'b01, 16'd6,  1'b0, 1'b0);
      wait_rsp("drain3", 8'd3, 8'd4, 2'b10, 16'd12, 1'b0, 1'b0);
      wait_rsp("drain4", 8'd7, 8'd8, 2'b00, 16'd15, 1'b0, 1'b0);
      @(negedge clk);
      chk("drained_busy", {31'd0, busy}, 32'd0);

`ifdef CALC_TIMEOUT_EN
      // DIV never completes: 2 cycles to reach WAIT plus 64 WAIT cycles
      div_hang = 1'b1;
      push(8'd9, 8'd3, 2'b11);
      measure_lat(lat);
      chk("tmo_latency", lat, 66);
      wait_rsp("tmo", 8'd9, 8'd3, 2'b11, 16'hFFFF, 1'b0, 1'b1);
      div_hang = 1'b0;
`endif

      // reset in the middle of a DIV with another command queued
      div_delay = 20;
      push(8'd50, 8'd7, 2'b11);
      push(8'd1, 8'd2, 2'b00);
      repeat (4) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      bus.rsp_ready = 1'b0;
      chk("no_stale_rsp", seen, 0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // recovers normally afterwards
      push(8'd3, 8'd4, 2'b00);
      wait_rsp("recover", 8'd3, 8'd4, 2'b00, 16'd7, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
